agex_stage_ex: RTL

AGEX_STAGE_EX -- requirements
Module: agex_stage_ex

---
 rtl/agex_stage_ex.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/agex_stage_ex.sv
// agex_stage_ex: execute/address-generation stage with single-cycle ALU and iterative shift-add MUL
// Ports: clk, reset (async active-low); in_valid/in_ready handshake from DE with in_op, in_a, in_b,
// in_imm, in_pc, in_inst_count, in_rd; out_* is the registered AGEX latch toward MEM;
// br_redirect/br_target is the registered one-cycle taken-branch/jump pulse to FE/DE.
module agex_stage_ex #(
  parameter int DBITS  = 32,
  parameter int MULCYC = DBITS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [DBITS-1:0] in_a,
  input  logic [DBITS-1:0] in_b,
  input  logic [DBITS-1:0] in_imm,
  input  logic [DBITS-1:0] in_pc,
  input  logic [DBITS-1:0] in_inst_count,
  input  logic [4:0]       in_rd,
  output logic             out_valid,
  output logic [DBITS-1:0] out_pc,
  output logic [DBITS-1:0] out_result,
  output logic [DBITS-1:0] out_memaddr,
  output logic [DBITS-1:0] out_wr_val,
  output logic [DBITS-1:0] out_inst_count,
  output logic [4:0]       out_rd,
  output logic             out_wr_mem,
  output logic             out_rd_mem,
  output logic             out_wr_reg,
  output logic             br_redirect,
  output logic [DBITS-1:0] br_target
);
  localparam int CW = (MULCYC > 1) ? $clog2(MULCYC) : 1;
  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4, OP_SLT = 4'd5, OP_SLL = 4'd6, OP_SRL = 4'd7;
  localparam logic [3:0] OP_LW = 4'd8, OP_SW = 4'd9, OP_BEQ = 4'd10, OP_BNE = 4'd11;
  localparam logic [3:0] OP_JAL = 4'd12, OP_MUL = 4'd13;
  typedef enum logic {IDLE, MUL_BUSY} state_t;
  typedef struct packed {
    logic             valid;
    logic [DBITS-1:0] pc;
    logic [DBITS-1:0] result;
    logic [DBITS-1:0] memaddr;
    logic [DBITS-1:0] wr_val;
    logic [DBITS-1:0] inst_count;
    logic [4:0]       rd;
    logic             wr_mem;
    logic             rd_mem;
    logic             wr_reg;
    logic             redirect;
    logic [DBITS-1:0] target;
  } lat_t;
  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DBITS-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
  logic [DBITS-1:0] alu, sum;
  logic             accept, taken, slt;
  lat_t             lat_q, lat_d;
  assign in_ready = state_q == IDLE;
  assign accept   = in_valid && in_ready;
  assign slt      = $signed(in_a) < $signed(in_b);
  assign taken    = (in_op == OP_BEQ && in_a == in_b) || (in_op == OP_BNE && in_a != in_b) ||
                    in_op == OP_JAL;
  assign sum      = acc_q + (mplier_q[0] ? mcand_q : '0);
  always_comb
    alu = in_op == OP_ADD ? in_a + in_b :
          in_op == OP_SUB ? in_a - in_b :
          in_op == OP_AND ? in_a & in_b :
          in_op == OP_OR  ? in_a | in_b :
          in_op == OP_XOR ? in_a ^ in_b :
          in_op == OP_SLT ? {{(DBITS-1){1'b0}}, slt} :
          in_op == OP_SLL ? in_a << in_b[4:0] :
          in_op == OP_SRL ? in_a >> in_b[4:0] :
          in_op == OP_JAL ? in_pc + DBITS'(4) : '0;
  // MUL captures pc/rd/count into the latch at acceptance (valid=0) and holds them
  // through the busy phase, so completion only has to fill in result and flags.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mcand_d      = mcand_q;
    mplier_d     = mplier_q;
    acc_d        = acc_q;
    lat_d        = lat_q;
    lat_d.valid    = 1'b0;
    lat_d.redirect = 1'b0;
    if (accept) begin
      lat_d.valid      = in_op != OP_MUL;
      lat_d.pc         = in_pc;
      lat_d.rd         = in_rd;
      lat_d.inst_count = in_inst_count;
      lat_d.result     = alu;
      lat_d.memaddr    = in_a + in_imm;
      lat_d.wr_val     = in_b;
      lat_d.wr_mem     = in_op == OP_SW;
      lat_d.rd_mem     = in_op == OP_LW;
      lat_d.wr_reg     = in_op <= OP_SRL || in_op == OP_LW || in_op == OP_JAL;
      lat_d.redirect   = taken;
      lat_d.target     = in_pc + in_imm;
      if (in_op == OP_MUL) begin
        state_d  = MUL_BUSY;
        cnt_d    = '0;
        mcand_d  = in_a;
        mplier_d = in_b;
        acc_d    = '0;
      end
    end else if (state_q == MUL_BUSY) begin
      acc_d    = sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q == CW'(MULCYC - 1) ? '0 : cnt_q + CW'(1);
      if (cnt_q == CW'(MULCYC - 1)) begin
        state_d      = IDLE;
        lat_d.valid  = 1'b1;
        lat_d.result = sum;
        lat_d.wr_reg = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      lat_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      lat_q    <= lat_d;
    end
  end
  assign out_valid      = lat_q.valid;
  assign out_pc         = lat_q.pc;
  assign out_result     = lat_q.result;
  assign out_memaddr    = lat_q.memaddr;
  assign out_wr_val     = lat_q.wr_val;
  assign out_inst_count = lat_q.inst_count;
  assign out_rd         = lat_q.rd;
  assign out_wr_mem     = lat_q.wr_mem;
  assign out_rd_mem     = lat_q.rd_mem;
  assign out_wr_reg     = lat_q.wr_reg;
  assign br_redirect    = lat_q.redirect;
  assign br_target      = lat_q.target;
endmodule
